trigger_capture_ctrl: RTL and testbench

TRIGGER_CAPTURE_CTRL -- requirements
Module: trigger_capture_ctrl

---
 rtl/trigger_capture_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_trigger_capture_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/trigger_capture_ctrl.sv
// Oscilloscope-style trigger/capture controller: decimates incoming samples, fills a circular
// frame buffer around a level/slope trigger and holds the frame for display. Optional macro AUTO_TRIG_EN.
module trigger_capture_ctrl #(
    parameter int SCREEN_WIDTH = 160,
    parameter int PRE_TRIG     = 80,
    parameter int AUTO_TIMEOUT = 48000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic signed [31:0] sample_in,
    input  logic        [2:0]  time_div,
    input  logic signed [31:0] trig_level,
    input  logic               trig_slope,
    input  logic               single,
    input  logic               arm,
    input  logic               display_ack,
    output logic               wr_en,
    output logic        [7:0]  wr_addr,
    output logic        [31:0] wr_data,
    output logic        [7:0]  frame_start,
    output logic               frame_ready,
    output logic        [2:0]  state,
    output logic               auto_trig
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRETRIG  = 3'd1,
        ST_ARMED    = 3'd2,
        ST_POSTTRIG = 3'd3,
        ST_HOLD     = 3'd4
    } state_t;

    localparam int         POST_N    = SCREEN_WIDTH - PRE_TRIG - 1;
    localparam logic [7:0] LAST_ADDR = 8'(SCREEN_WIDTH - 1);
    localparam logic [7:0] PRE_W     = 8'(PRE_TRIG);
    localparam logic [7:0] PRE_LAST  = 8'(PRE_TRIG - 1);
    localparam logic [7:0] POST_OFF  = 8'(SCREEN_WIDTH - PRE_TRIG);
    localparam logic [7:0] POST_LAST = 8'((POST_N > 0) ? POST_N - 1 : 0);

    state_t             state_r, next_state_s;
    logic        [2:0]  dec_cnt_r;
    logic        [7:0]  wr_ptr_r, pre_cnt_r, post_cnt_r, frame_start_s;
    logic signed [31:0] prev_r;
    logic               prev_valid_r;
    logic               capturing_s, accept_s, real_trig_s, force_trig_s, trig_s, enter_pretrig_s;

    // Acceptance, trigger detection and frame-start arithmetic.
    always_comb begin
        capturing_s   = (state_r == ST_PRETRIG) || (state_r == ST_ARMED) || (state_r == ST_POSTTRIG);
        accept_s      = capturing_s && sample_valid && (dec_cnt_r >= time_div);
        real_trig_s   = 1'b0;
        if (accept_s && (state_r == ST_ARMED) && prev_valid_r) begin
            if (trig_slope) begin
                real_trig_s = (prev_r > trig_level) && (sample_in <= trig_level);
            end else begin
                real_trig_s = (prev_r < trig_level) && (sample_in >= trig_level);
            end
        end else begin
            real_trig_s = 1'b0;
        end
        trig_s        = real_trig_s || force_trig_s;
        frame_start_s = (wr_ptr_r >= PRE_W) ? (wr_ptr_r - PRE_W) : (wr_ptr_r + POST_OFF);
    end

`ifdef AUTO_TRIG_EN
    logic [31:0] auto_cnt_r;

    assign force_trig_s = accept_s && (state_r == ST_ARMED) && !real_trig_s &&
                          (auto_cnt_r == 32'(AUTO_TIMEOUT - 1));

    // Timeout counter of accepted samples while armed; auto_trig marks forced frames.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            auto_cnt_r <= 32'd0;
            auto_trig  <= 1'b0;
        end else begin
            if ((state_r == ST_PRETRIG) && (next_state_s == ST_ARMED)) begin
                auto_cnt_r <= 32'd0;
            end else if (accept_s && (state_r == ST_ARMED)) begin
                auto_cnt_r <= auto_cnt_r + 32'd1;
            end
            if (force_trig_s) begin
                auto_trig <= 1'b1;
            end else if (real_trig_s) begin
                auto_trig <= 1'b0;
            end
        end
    end
`else
    assign force_trig_s = 1'b0;
    assign auto_trig    = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (arm) next_state_s = ST_PRETRIG;
                else     next_state_s = state_r;
            end
            ST_PRETRIG: begin
                if (accept_s && (pre_cnt_r == PRE_LAST)) next_state_s = ST_ARMED;
                else                                     next_state_s = state_r;
            end
            ST_ARMED: begin
                if (trig_s) next_state_s = (POST_N > 0) ? ST_POSTTRIG : ST_HOLD;
                else        next_state_s = state_r;
            end
            ST_POSTTRIG: begin
                if (accept_s && (post_cnt_r == POST_LAST)) next_state_s = ST_HOLD;
                else                                       next_state_s = state_r;
            end
            ST_HOLD: begin
                if (display_ack) next_state_s = single ? ST_IDLE : ST_PRETRIG;
                else             next_state_s = state_r;
            end
            default: next_state_s = ST_IDLE;
        endcase
        enter_pretrig_s = (next_state_s == ST_PRETRIG) && (state_r != ST_PRETRIG);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= ST_IDLE;
        else        state_r <= next_state_s;
    end

    assign state = state_r;

    // Capture datapath: decimation, buffer writes, counters and frame bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dec_cnt_r    <= 3'd0;
            wr_ptr_r     <= 8'd0;
            pre_cnt_r    <= 8'd0;
            post_cnt_r   <= 8'd0;
            prev_r       <= 32'sd0;
            prev_valid_r <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= 8'd0;
            wr_data      <= 32'd0;
            frame_start  <= 8'd0;
            frame_ready  <= 1'b0;
        end else begin
            wr_en       <= accept_s;
            frame_ready <= (next_state_s == ST_HOLD);
            if (enter_pretrig_s) begin
                dec_cnt_r <= 3'd0;
            end else if (sample_valid) begin
                dec_cnt_r <= (dec_cnt_r >= time_div) ? 3'd0 : dec_cnt_r + 3'd1;
            end
            if (accept_s) begin
                wr_data      <= sample_in;
                wr_addr      <= wr_ptr_r;
                wr_ptr_r     <= (wr_ptr_r == LAST_ADDR) ? 8'd0 : wr_ptr_r + 8'd1;
                prev_r       <= sample_in;
                prev_valid_r <= 1'b1;
            end
            // A fresh arm restarts the buffer; a continuous re-arm keeps the pointer running.
            if ((state_r == ST_IDLE) && arm) begin
                wr_ptr_r <= 8'd0;
            end
            if (enter_pretrig_s) begin
                pre_cnt_r    <= 8'd0;
                prev_valid_r <= 1'b0;
            end else if (accept_s && (state_r == ST_PRETRIG)) begin
                pre_cnt_r <= pre_cnt_r + 8'd1;
            end
            if (trig_s) begin
                post_cnt_r  <= 8'd0;
                frame_start <= frame_start_s;
            end else if (accept_s && (state_r == ST_POSTTRIG)) begin
                post_cnt_r <= post_cnt_r + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_trigger_capture_ctrl.sv
// Directed self-checking bench for trigger_capture_ctrl (default parameters, AUTO_TRIG_EN undefined).
module tb_trigger_capture_ctrl;

    logic               clk;
    logic               reset;
    logic               sample_valid;
    logic signed [31:0] sample_in;
    logic        [2:0]  time_div;
    logic signed [31:0] trig_level;
    logic               trig_slope;
    logic               single;
    logic               arm;
    logic               display_ack;
    logic               wr_en;
    logic        [7:0]  wr_addr;
    logic        [31:0] wr_data;
    logic        [7:0]  frame_start;
    logic               frame_ready;
    logic        [2:0]  state;
    logic               auto_trig;

    int errors = 0;
    int checks = 0;

    trigger_capture_ctrl dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
        .time_div(time_div), .trig_level(trig_level), .trig_slope(trig_slope),
        .single(single), .arm(arm), .display_ack(display_ack), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .frame_start(frame_start),
        .frame_ready(frame_ready), .state(state), .auto_trig(auto_trig)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one sample strobe for one clock; returns on the following falling edge.
    task automatic send(input logic signed [31:0] s);
        sample_valid = 1'b1;
        sample_in    = s;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1; sample_valid = 1'b0; sample_in = 32'sd0; time_div = 3'd0;
        trig_level = 32'sd0; trig_slope = 1'b0; single = 1'b1; arm = 1'b0; display_ack = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_frame_ready", 32'(frame_ready), 32'd0);
        check("rst_auto_trig", 32'(auto_trig), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Decimation by 3: writes after strobes 3, 6, 9 at addresses 0, 1, 2.
        time_div = 3'd2;
        pulse_arm();
        check("dec_state", 32'(state), 32'd1);
        for (int i = 1; i <= 9; i++) begin
            send(32'(i));
            check("dec_wr_en", 32'(wr_en), 32'((i % 3) == 0));
            if ((i % 3) == 0) begin
                check("dec_addr", 32'(wr_addr), 32'(i / 3 - 1));
                check("dec_data", wr_data, 32'(i));
            end
        end
        do_reset();

        // Ramp -100..79, rising through 0: trigger at address 100, frame_start 20, hold after address 19.
        time_div = 3'd0; trig_level = 32'sd0; trig_slope = 1'b0; single = 1'b1;
        pulse_arm();
        for (int v = -100; v <= 79; v++) begin
            send(32'(v));
            check("ramp_wr_en", 32'(wr_en), 32'd1);
            check("ramp_addr", 32'(wr_addr), 32'((v + 100) % 160));
            if (v == -21) check("ramp_armed", 32'(state), 32'd2);
            if (v == 0) begin
                check("ramp_trig_state", 32'(state), 32'd3);
                check("ramp_trig_data", wr_data, 32'd0);
                check("ramp_frame_start", 32'(frame_start), 32'd20);
            end
            if (v == 78) check("ramp_not_ready", 32'(frame_ready), 32'd0);
        end
        check("ramp_hold_state", 32'(state), 32'd4);
        check("ramp_frame_ready", 32'(frame_ready), 32'd1);

        // HOLD ignores strobes and arm; arm together with ack acts as ack (single -> IDLE).
        send(32'sd5);
        check("hold_no_write", 32'(wr_en), 32'd0);
        pulse_arm();
        check("hold_arm_ignored", 32'(state), 32'd4);
        arm = 1'b1; display_ack = 1'b1;
        @(negedge clk);
        arm = 1'b0; display_ack = 1'b0;
        check("single_ack_idle", 32'(state), 32'd0);
        check("idle_not_ready", 32'(frame_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            send(32'sd5);
            check("idle_no_write", 32'(wr_en), 32'd0);
        end
        display_ack = 1'b1;
        @(negedge clk);
        display_ack = 1'b0;
        check("idle_ack_ignored", 32'(state), 32'd0);

        // Continuous mode: ack re-enters PRETRIG and the pointer continues from 20.
        single = 1'b0;
        pulse_arm();
        for (int v = -100; v <= 79; v++) send(32'(v));
        check("cont_hold", 32'(state), 32'd4);
        check("cont_last_addr", 32'(wr_addr), 32'd19);
        display_ack = 1'b1;
        @(negedge clk);
        display_ack = 1'b0;
        check("cont_rearm", 32'(state), 32'd1);
        send(32'sd7);
        check("cont_wr_en", 32'(wr_en), 32'd1);
        check("cont_addr", 32'(wr_addr), 32'd20);
        check("cont_data", wr_data, 32'd7);
        do_reset();

        // No crossing: stays ARMED indefinitely with no forced trigger.
        single = 1'b1; trig_level = 32'sd100;
        pulse_arm();
        for (int i = 0; i < 130; i++) send(32'sd0);
        check("noauto_state", 32'(state), 32'd2);
        check("noauto_flag", 32'(auto_trig), 32'd0);
        do_reset();

        // Falling slope at 500: rising crossing ignored, trigger on 700 -> 400 at address 83.
        trig_level = 32'sd500; trig_slope = 1'b1;
        pulse_arm();
        for (int i = 0; i < 80; i++) send(32'sd0);
        send(32'sd0);
        send(32'sd600);
        check("fall_rise_ignored", 32'(state), 32'd2);
        send(32'sd700);
        check("fall_still_armed", 32'(state), 32'd2);
        send(32'sd400);
        check("fall_trig_state", 32'(state), 32'd3);
        check("fall_trig_addr", 32'(wr_addr), 32'd83);
        check("fall_trig_data", wr_data, 32'd400);
        check("fall_frame_start", 32'(frame_start), 32'd3);
        for (int i = 0; i < 10; i++) send(32'sd300);
        check("post_state", 32'(state), 32'd3);

        // Reset during POSTTRIG clears outputs without a clock edge.
        reset = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_addr", 32'(wr_addr), 32'd0);
        check("mid_rst_data", wr_data, 32'd0);
        check("mid_rst_fstart", 32'(frame_start), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(32'sd123);
            check("post_rst_no_write", 32'(wr_en), 32'd0);
        end
        check("post_rst_state", 32'(state), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
